// File: rtl/fn_division_serie.sv
// Serial 32-bit restoring divider with signed/unsigned modes.
// One quotient bit per cycle; a fixed 33-cycle latency from the accept edge to listo.
module fn_division_serie (
  input  logic        clk,
  input  logic        nreset,
  input  logic        inicio,
  input  logic        con_signo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] Y,
  output logic [31:0] R,
  output logic        ocupado,
  output logic        listo
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    AJUSTE  = 2'd2
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] div_q, div_d;
  logic [31:0] a_q, a_d;
  logic [31:0] y_q, y_d;
  logic [31:0] r_q, r_d;
  logic        neg_y_q, neg_y_d;
  logic        neg_r_q, neg_r_d;
  logic        b_cero_q, b_cero_d;
  logic        ocupado_q, ocupado_d;
  logic        listo_q, listo_d;

  logic [31:0] a_mag_s, b_mag_s;
  logic [32:0] rem_sh_s, dif_s;

  // Next-state, datapath step and result adjustment
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    div_d     = div_q;
    a_d       = a_q;
    y_d       = y_q;
    r_d       = r_q;
    neg_y_d   = neg_y_q;
    neg_r_d   = neg_r_q;
    b_cero_d  = b_cero_q;
    listo_d   = 1'b0;

    a_mag_s   = (con_signo && a[31]) ? (32'd0 - a) : a;
    b_mag_s   = (con_signo && b[31]) ? (32'd0 - b) : b;
    // 33-bit window: the shifted remainder can reach almost twice the divisor
    rem_sh_s  = {rem_q, quot_q[31]};
    dif_s     = rem_sh_s - {1'b0, div_q};

    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          a_d      = a;
          rem_d    = 32'd0;
          quot_d   = a_mag_s;
          div_d    = b_mag_s;
          neg_y_d  = con_signo & (a[31] ^ b[31]);
          neg_r_d  = con_signo & a[31];
          b_cero_d = (b == 32'd0);
          cnt_d    = 6'd0;
          estado_d = CALCULO;
        end else begin
          estado_d = REPOSO;
        end
      end
      CALCULO: begin
        if (!dif_s[32]) begin
          rem_d  = dif_s[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_sh_s[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          estado_d = AJUSTE;
        end else begin
          estado_d = CALCULO;
        end
      end
      AJUSTE: begin
        if (b_cero_q) begin
          y_d = 32'hFFFF_FFFF;
          r_d = a_q;
        end else begin
          y_d = neg_y_q ? (32'd0 - quot_q) : quot_q;
          r_d = neg_r_q ? (32'd0 - rem_q) : rem_q;
        end
        listo_d  = 1'b1;
        estado_d = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase

    ocupado_d = (estado_d != REPOSO);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado_q  <= REPOSO;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quot_q    <= 32'd0;
      div_q     <= 32'd0;
      a_q       <= 32'd0;
      y_q       <= 32'd0;
      r_q       <= 32'd0;
      neg_y_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      b_cero_q  <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      div_q     <= div_d;
      a_q       <= a_d;
      y_q       <= y_d;
      r_q       <= r_d;
      neg_y_q   <= neg_y_d;
      neg_r_q   <= neg_r_d;
      b_cero_q  <= b_cero_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
    end
  end

  assign Y       = y_q;
  assign R       = r_q;
  assign ocupado = ocupado_q;
  assign listo   = listo_q;

endmodule

// File: tb/tb_fn_division_serie.sv
// Directed and randomized self-checking bench for fn_division_serie.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fn_division_serie;

  logic        clk;
  logic        nreset;
  logic        inicio;
  logic        con_signo;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] Y;
  logic [31:0] R;
  logic        ocupado;
  logic        listo;

  int total = 0;
  int bad   = 0;

  fn_division_serie dut (
    .clk       (clk),
    .nreset    (nreset),
    .inicio    (inicio),
    .con_signo (con_signo),
    .a         (a),
    .b         (b),
    .Y         (Y),
    .R         (R),
    .ocupado   (ocupado),
    .listo     (listo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {q, r};
  endfunction

  // Present operands with inicio=1 and return at the falling edge after the accept edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    a         = x;
    b         = y;
    con_signo = s;
    inicio    = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count edges after the accept edge until listo; busy counts ocupado samples.
  task automatic wait_done(output int cyc, output int busy);
    cyc  = -1;
    busy = int'(ocupado);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (listo) begin
        cyc = k;
        break;
      end
      busy += int'(ocupado);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] ey, input logic [31:0] er);
    int cyc;
    int busy;
    start_op(x, y, s);
    inicio = 1'b0;
    wait_done(cyc, busy);
    check("latency", 32'(cyc), 32'd33);
    check("ocupado_cycles", 32'(busy), 32'd33);
    check("ocupado_at_listo", {31'd0, ocupado}, 32'd0);
    check("Y", Y, ey);
    check("R", R, er);
    check("identity", Y * y + R, x);
    @(negedge clk);
    check("listo_one_cycle", {31'd0, listo}, 32'd0);
    check("Y_hold", Y, ey);
    check("R_hold", R, er);
  endtask

  initial begin
    int          cyc;
    int          busy;
    int          pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] m;

    nreset    = 1'b0;
    inicio    = 1'b0;
    con_signo = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    #3;
    check("rst_Y", Y, 32'd0);
    check("rst_R", R, 32'd0);
    check("rst_ocupado", {31'd0, ocupado}, 32'd0);
    check("rst_listo", {31'd0, listo}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;

    run_op(32'd15, 32'd10, 1'b0, 32'd1, 32'd5);
    run_op(32'hFFFF_FFF1, 32'd4, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
    run_op(32'd15, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFD, 32'd3);
    run_op(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234);
    run_op(32'd1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1234);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0);

    // inicio held high with changing operands, then a start in the listo cycle
    start_op(32'd100, 32'd7, 1'b0);
    a = 32'd999;
    b = 32'd3;
    wait_done(cyc, busy);
    check("held_latency", 32'(cyc), 32'd33);
    check("held_Y", Y, 32'd14);
    check("held_R", R, 32'd2);
    a = 32'd50;
    b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    check("b2b_busy", {31'd0, ocupado}, 32'd1);
    check("b2b_Y_hold", Y, 32'd14);
    wait_done(cyc, busy);
    check("b2b_latency", 32'(cyc), 32'd33);
    check("b2b_Y", Y, 32'd10);
    check("b2b_R", R, 32'd0);

    // asynchronous reset in the middle of CALCULO
    start_op(32'd1000, 32'd3, 1'b0);
    inicio = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check("arst_Y", Y, 32'd0);
    check("arst_R", R, 32'd0);
    check("arst_ocupado", {31'd0, ocupado}, 32'd0);
    check("arst_listo", {31'd0, listo}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      pulses += int'(listo) + int'(ocupado);
    end
    check("arst_no_listo", 32'(pulses), 32'd0);
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case (i % 8)
        1: rb = 32'($urandom_range(0, 15));
        2: rb = 32'd0 - 32'($urandom_range(1, 15));
        3: rb = 32'd0;
        4: ra = 32'h8000_0000;
        5: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        6: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      m = ref_div(ra, rb, rs);
      run_op(ra, rb, rs, m[63:32], m[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
